// File: rtl/count_display.sv
// Captures the 8-bit counter on a strobe and converts it to BCD with a sequential
// double-dabble engine; drives three 7-segment displays only once a value is fully converted.
//
//   state | meaning
//   IDLE  | waiting for sample or a pending request
//   SHIFT | one add-3/shift iteration per clock, 8 in total
//   DONE  | commit converted value to bcd/hex, pulse done
module count_display #(
    parameter int BLANK_LEADING  = 1,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] count,
    input  logic       sample,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2,
    output logic [11:0] bcd,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [19:0] shreg;
    logic [2:0]  it;
    logic        pending;
    logic        load;
    logic        shift_en;
    logic        commit;

    function automatic logic [19:0] dabble_step(input logic [19:0] s);
        logic [19:0] r;
        r = s;
        for (int i = 0; i < 3; i++) begin
            if (r[8+4*i +: 4] >= 4'd5)
                r[8+4*i +: 4] = r[8+4*i +: 4] + 4'd3;
        end
        return {r[18:0], 1'b0};
    endfunction

    // Active-low code table, then flipped for active-high boards.
    function automatic logic [6:0] seg_code(input logic [3:0] d, input logic blank);
        logic [6:0] c;
        if (blank) c = 7'b1111111;
        else begin
            case (d)
                4'd0:    c = 7'b1000000;
                4'd1:    c = 7'b1111001;
                4'd2:    c = 7'b0100100;
                4'd3:    c = 7'b0110000;
                4'd4:    c = 7'b0011001;
                4'd5:    c = 7'b0010010;
                4'd6:    c = 7'b0000010;
                4'd7:    c = 7'b1111000;
                4'd8:    c = 7'b0000000;
                4'd9:    c = 7'b0010000;
                default: c = 7'b1111111;
            endcase
        end
        return (SEG_ACTIVE_LOW != 0) ? c : ~c;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sample || pending) state_nxt = SHIFT;
            SHIFT:   if (it == 3'd7) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        load     = (state == IDLE) && (sample || pending);
        shift_en = (state == SHIFT);
        commit   = (state == DONE);
        busy     = (state != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg   <= '0;
            it      <= '0;
            pending <= 1'b0;
        end else begin
            if (load) begin
                shreg <= {12'b0, count};
                it    <= 3'd0;
            end else if (shift_en) begin
                shreg <= dabble_step(shreg);
                it    <= it + 3'd1;
            end
            // Strobes during a conversion collapse into a single follow-up request.
            if (load)              pending <= 1'b0;
            else if (busy && sample) pending <= 1'b1;
        end
    end

    logic blank_h;
    logic blank_t;
    assign blank_h = (BLANK_LEADING != 0) && (shreg[19:16] == 4'd0);
    assign blank_t = blank_h && (shreg[15:12] == 4'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bcd  <= 12'h000;
            done <= 1'b0;
            hex0 <= seg_code(4'd0, 1'b0);
            hex1 <= seg_code(4'd0, BLANK_LEADING != 0);
            hex2 <= seg_code(4'd0, BLANK_LEADING != 0);
        end else begin
            done <= commit;
            if (commit) begin
                bcd  <= shreg[19:8];
                hex0 <= seg_code(shreg[11:8], 1'b0);
                hex1 <= seg_code(shreg[15:12], blank_t);
                hex2 <= seg_code(shreg[19:16], blank_h);
            end
        end
    end

endmodule
